// File: rtl/tt_serial_addsub_pkg.sv
// tt_serial_addsub_pkg: shared FSM states, mode codes and pin indices for the serial add/sub core
package tt_serial_addsub_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
   localparam int UI_A     = 0;
   localparam int UI_B     = 1;
   localparam int UI_START = 2;
   localparam int UI_MODE  = 3;
   localparam int UI_VALID = 4;
   localparam int UO_SUM   = 0;
   localparam int UO_COUT  = 1;
   localparam int UO_BUSY  = 2;
   localparam int UO_DONE  = 3;
   localparam int UO_OVF   = 4;
endpackage

// File: rtl/tt_um_serial_addsub_fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/tt_um_serial_addsub.sv
// tt_um_serial_addsub: bit-serial LSB-first adder/subtractor with IDLE/RUN/DONE control
module tt_um_serial_addsub
   import tt_serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   localparam int CW = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_mode;
   logic             r_carry;
   logic             r_sum;
   logic             r_ovf;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_shift;
   logic             w_start;
   logic             w_accept;
   logic             w_last;
   logic             w_b;
   logic             w_s;
   logic             w_cout;
   logic             w_unused;

   // start is honoured only outside RUN; a bit pair is consumed only in RUN with valid
   assign w_start  = ui_in[UI_START] && (r_state != RUN);
   assign w_accept = (r_state == RUN) && ui_in[UI_VALID];
   assign w_last   = w_accept && (r_cnt == CW'(WIDTH - 1));
   // subtraction is A + ~B + 1, the +1 coming from the carry preset at start
   assign w_b      = ui_in[UI_B] ^ (r_mode == MODE_SUB);

   fa_cell u_fa (
      .a   (ui_in[UI_A]),
      .b   (w_b),
      .cin (r_carry),
      .s   (w_s),
      .cout(w_cout)
   );

   // new sum bit enters at the MSB so the LSB-first stream ends up in place
   assign w_result_shift = (r_result >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // next state: DONE (and any illegal code) falls back to IDLE unless restarted
   always_comb begin
      w_state_nxt = r_state;
      if (w_start)               w_state_nxt = RUN;
      else if (r_state != RUN)   w_state_nxt = IDLE;
      else if (w_last)           w_state_nxt = DONE;
   end

   // datapath: initialise on start, shift one bit per accepted pair, capture overflow on the last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode   <= MODE_ADD;
         r_carry  <= 1'b0;
         r_sum    <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_start) begin
         r_mode   <= ui_in[UI_MODE];
         r_carry  <= ui_in[UI_MODE];
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_carry  <= w_cout;
         r_sum    <= w_s;
         r_result <= w_result_shift;
         r_cnt    <= r_cnt + 1'b1;
         r_ovf    <= w_last ? (r_carry ^ w_cout) : r_ovf;
      end
   end

   // status pins
   always_comb begin
      uo_out          = '0;
      uo_out[UO_SUM]  = r_sum;
      uo_out[UO_COUT] = r_carry;
      uo_out[UO_BUSY] = (r_state == RUN);
      uo_out[UO_DONE] = (r_state == DONE);
      uo_out[UO_OVF]  = r_ovf;
   end

   assign uio_out  = 8'(r_result);
   assign uio_oe   = 8'hFF;
   assign w_unused = &{1'b0, ena, uio_in, ui_in[7:5]};
endmodule

// File: doc/tt_um_serial_addsub.md
TT_UM_SERIAL_ADDSUB -- requirements
Module: tt_um_serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, legal range 1..8; sets the operand and result length in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  always 1 when powered; ignored.
REQ-005 ui_in  input  8  control and data inputs:
- [0] a_bit: operand A serial bit, LSB first.
- [1] b_bit: operand B serial bit, LSB first.
- [2] start.
- [3] mode: 0=add, 1=subtract (A-B).
- [4] valid.
- [7:5] unused.
REQ-006 uo_out  output  8  status outputs:
- [0] sum_bit: last registered sum bit.
- [1] carry_out.
- [2] busy.
- [3] done.
- [4] overflow (signed).
- [7:5] fixed 0.
REQ-007 uio_in  input  8  unused.
REQ-008 uio_out  output  8  result register, zero-extended to 8 bits.
REQ-009 uio_oe  output  8  constant 8'hFF.

Function
REQ-010 FSM states are IDLE, RUN and DONE.
REQ-011 IDLE transitions:
- start=1 -> RUN.
- Latch mode.
- Carry <= mode.
- Bit counter <= 0.
- Result <= 0.
REQ-012 In RUN, a cycle with valid=1 accepts one bit pair:
- b' = b_bit XOR mode.
- s = a_bit XOR b' XOR carry.
- carry <= majority(a_bit, b', carry).
- sum_bit <= s.
- result <= {s, result[WIDTH-1:1]}.
- counter increments.
REQ-013 In RUN, a cycle with valid=0 is a stall; no state changes.
REQ-014 In RUN, start is ignored; mode stays as latched.
REQ-015 In RUN, acceptance of the WIDTH-th bit moves the FSM to DONE on that edge.
REQ-016 On that same edge, overflow <= (carry into the MSB stage) XOR (carry out of the MSB stage).
REQ-017 Bits are never sampled in the start cycle; with valid held high, done is visible in the cycle after edge WIDTH+1 counted from the start edge.
REQ-018 DONE lasts exactly one cycle, with done=1 for that cycle.
REQ-019 DONE exits to IDLE, or to RUN when start=1, applying the same initialisation as REQ-011.
REQ-020 busy=1 exactly when the state is RUN.
REQ-021 Result, carry_out and overflow hold their final values until the next accepted start.
REQ-022 In subtract mode, carry_out=1 means no borrow; it is presented raw, not inverted.
REQ-023 The counter is clog2(WIDTH+1) bits wide and never wraps: it saturates at WIDTH by the state change.
REQ-024 For WIDTH<8, uio_out[7:WIDTH] are 0.

Reset
REQ-025 rst_n=0 forces the following, asynchronously:
- state = IDLE.
- result, carry, counter, sum_bit, overflow and latched mode all = 0.
- uo_out = 8'h00.
- uio_out = 8'h00.
REQ-026 Reset asserted mid-RUN discards the partial operation; after release, only a new start begins an operation.
REQ-027 Deassertion of rst_n is sampled synchronously; the first start is honoured on the first edge after release.

Structure
REQ-028 A shared package tt_serial_addsub_pkg holds:
- the FSM state enum (IDLE/RUN/DONE);
- the mode constants MODE_ADD/MODE_SUB;
- the uo_out bit-index constants.
REQ-029 The combinational 1-bit full adder is one sub-module, fa_cell (inputs a, b, cin; outputs s, cout), instantiated once.

Verification
REQ-030 WIDTH=8, add, A=0x35, B=0x4A, valid held high -> result 0x7F, carry_out 0, overflow 0, done for one cycle.
REQ-031 add, A=0xFF, B=0x01 -> result 0x00, carry_out 1, overflow 0; add, A=0x7F, B=0x01 -> result 0x80, overflow 1.
REQ-032 subtract, A=0x05, B=0x07 -> result 0xFE, carry_out 0; subtract, A=0x07, B=0x05 -> result 0x02, carry_out 1.
REQ-033 Stall and start-ignore case:
- Stimulus: valid low for 3 cycles after bit 3, and start pulsed mid-RUN.
- Required response: same result as unstalled; busy stays 1; no restart occurs.
REQ-034 Reset and back-to-back case:
- Stimulus: rst_n low after bit 5.
- Required response: all outputs 0 and state IDLE immediately.
- Follow-up: a new start with start=1 in the DONE cycle of the following operation must begin RUN with no intervening IDLE cycle.
REQ-035 WIDTH=3, add, A=3'b101, B=3'b011 -> result 3'b000, carry_out 1, overflow 0, uio_out 8'h00.
